// File: rtl/quad_encoder_counter_if.sv
// -----------------------------------------------------------------------------
// quad_encoder_counter_if
// Groups the encoder pins, the position control inputs and the decoded outputs
// of quad_encoder_counter into one bundle.
//   i_phase_a / i_phase_b : raw, asynchronous encoder phases
//   i_clear               : synchronous clear of position and sticky error
//   i_load / i_load_val   : synchronous load of the position register
//   o_cnt / o_cnt_cw      : one-cycle step pulse and its direction (1 = CW)
//   o_pos                 : signed two's-complement position
//   o_err / o_err_flag    : illegal-transition pulse and its sticky flag
// Modports:
//   slave  - the counter itself (consumes pins/controls, drives results)
//   master - the user side (drives pins/controls, observes results)
// -----------------------------------------------------------------------------
interface quad_encoder_counter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 i_phase_a;
    logic                 i_phase_b;
    logic                 i_clear;
    logic                 i_load;
    logic [CNT_WIDTH-1:0] i_load_val;
    logic                 o_cnt;
    logic                 o_cnt_cw;
    logic [CNT_WIDTH-1:0] o_pos;
    logic                 o_err;
    logic                 o_err_flag;

    modport slave (
        input  i_phase_a,
        input  i_phase_b,
        input  i_clear,
        input  i_load,
        input  i_load_val,
        output o_cnt,
        output o_cnt_cw,
        output o_pos,
        output o_err,
        output o_err_flag
    );

    modport master (
        output i_phase_a,
        output i_phase_b,
        output i_clear,
        output i_load,
        output i_load_val,
        input  o_cnt,
        input  o_cnt_cw,
        input  o_pos,
        input  o_err,
        input  o_err_flag
    );
endinterface

// File: rtl/quad_encoder_counter.sv
// -----------------------------------------------------------------------------
// quad_encoder_counter
// Incremental quadrature encoder driver. The raw A/B phases are brought into
// the clock domain through a SYNC_STAGES-deep synchroniser, decoded at x1, x2
// or x4 resolution and accumulated into a signed position register that either
// wraps or saturates. Double-phase jumps are flagged as errors.
//
// Ports:
//   i_clk  - system clock, everything on the rising edge
//   i_rst  - asynchronous, active-high reset
//   bus    - quad_encoder_counter_if.slave (pins, clear/load, results)
//
// Parameters:
//   CNT_WIDTH   4..32  width of the signed position register
//   SYNC_STAGES 2..4   synchroniser depth per phase
//   MODE        0 = x1, 1 = x2, 2 = x4 (3 is not a legal setting)
//   WRAP        1 = modulo wrap, 0 = saturate at signed max/min
//
// Decoding scheme:
//   A quarter accumulator q tracks Gray steps since the last "anchor" state.
//   Entering an anchor resets q; a count is issued only when q reached exactly
//   +period or -period, so a partial or reversed cycle (contact bounce, jitter
//   around an edge) never produces a count. This is why no external debouncer
//   is needed in front of the pins.
// -----------------------------------------------------------------------------
module quad_encoder_counter #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0,
    parameter int WRAP        = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    quad_encoder_counter_if.slave  bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Number of quarter steps between two anchors for the chosen resolution.
    localparam logic signed [3:0] PERIOD =
        (MODE == 1) ? 4'sd2 :
        (MODE == 2) ? 4'sd1 : 4'sd4;
    localparam logic signed [3:0] NEG_PERIOD = -PERIOD;

    localparam logic [CNT_WIDTH-1:0] POS_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0] POS_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] POS_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] POS_ZERO = {CNT_WIDTH{1'b0}};

    localparam logic [2:0] FILL_LAST = 3'(SYNC_STAGES);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // True when from -> to is one clockwise Gray step (A leads):
    // 00 -> 10 -> 11 -> 01 -> 00. A CCW step is the same test with the
    // arguments swapped.
    function automatic logic is_cw_step(input logic [1:0] from_ab,
                                        input logic [1:0] to_ab);
        logic res;
        case ({from_ab, to_ab})
            4'b00_10: res = 1'b1;
            4'b10_11: res = 1'b1;
            4'b11_01: res = 1'b1;
            4'b01_00: res = 1'b1;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

    // Anchor states: x1 only 00, x2 00 and 11, x4 every state.
    function automatic logic is_anchor(input logic [1:0] ab);
        logic res;
        case (MODE)
            0:       res = (ab == 2'b00);
            1:       res = (ab == 2'b00) || (ab == 2'b11);
            2:       res = 1'b1;
            default: res = (ab == 2'b00);
        endcase
        return res;
    endfunction

    // Position +1 with wrap or saturation at the signed maximum.
    function automatic logic [CNT_WIDTH-1:0] pos_inc(input logic [CNT_WIDTH-1:0] p);
        logic [CNT_WIDTH-1:0] res;
        if ((WRAP == 0) && (p == POS_MAX)) begin
            res = p;
        end else begin
            res = p + POS_ONE;
        end
        return res;
    endfunction

    // Position -1 with wrap or saturation at the signed minimum.
    function automatic logic [CNT_WIDTH-1:0] pos_dec(input logic [CNT_WIDTH-1:0] p);
        logic [CNT_WIDTH-1:0] res;
        if ((WRAP == 0) && (p == POS_MIN)) begin
            res = p;
        end else begin
            res = p - POS_ONE;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_a_r;
    logic [SYNC_STAGES-1:0] sync_b_r;
    logic [0:0]             state_r;
    logic [2:0]             fill_r;
    logic [1:0]             prev_r;
    logic signed [3:0]      q_r;

    logic [1:0]             phase_s;
    logic                   run_s;
    logic                   step_cw_s;
    logic                   step_ccw_s;
    logic                   both_s;
    logic signed [3:0]      q_step_s;
    logic signed [3:0]      q_nxt_s;
    logic                   cnt_s;
    logic                   cnt_cw_s;
    logic                   err_s;
    logic [CNT_WIDTH-1:0]   pos_nxt_s;

    // Two-flop (or deeper) synchroniser for each raw phase.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_a_r <= {SYNC_STAGES{1'b0}};
            sync_b_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_a_r <= {sync_a_r[SYNC_STAGES-2:0], bus.i_phase_a};
            sync_b_r <= {sync_b_r[SYNC_STAGES-2:0], bus.i_phase_b};
        end
    end

    // Phase classification against the previously decoded phase word.
    always_comb begin
        phase_s    = {sync_a_r[SYNC_STAGES-1], sync_b_r[SYNC_STAGES-1]};
        run_s      = (state_r == ST_RUN);
        step_cw_s  = is_cw_step(prev_r, phase_s);
        step_ccw_s = is_cw_step(phase_s, prev_r);
        both_s     = ((prev_r ^ phase_s) == 2'b11);
        if (step_cw_s) begin
            q_step_s = q_r + 4'sd1;
        end else begin
            q_step_s = q_r - 4'sd1;
        end
    end

    // Quarter accumulator update and count/error decision.
    always_comb begin
        q_nxt_s  = q_r;
        cnt_s    = 1'b0;
        cnt_cw_s = 1'b0;
        err_s    = 1'b0;
        if (run_s && both_s) begin
            // Lost a state: direction unknown, restart the cycle.
            err_s   = 1'b1;
            q_nxt_s = 4'sd0;
        end else if (run_s && (step_cw_s || step_ccw_s)) begin
            if (is_anchor(phase_s)) begin
                // Only a complete cycle in one direction counts; anything
                // else reaching the anchor is discarded.
                q_nxt_s = 4'sd0;
                if (q_step_s == PERIOD) begin
                    cnt_s    = 1'b1;
                    cnt_cw_s = 1'b1;
                end else if (q_step_s == NEG_PERIOD) begin
                    cnt_s    = 1'b1;
                    cnt_cw_s = 1'b0;
                end else begin
                    cnt_s    = 1'b0;
                    cnt_cw_s = 1'b0;
                end
            end else begin
                q_nxt_s = q_step_s;
            end
        end else begin
            q_nxt_s = q_r;
        end
    end

    // Next position: clear beats load beats a counted step.
    always_comb begin
        pos_nxt_s = bus.o_pos;
        if (bus.i_clear) begin
            pos_nxt_s = POS_ZERO;
        end else if (bus.i_load) begin
            pos_nxt_s = bus.i_load_val;
        end else if (cnt_s) begin
            if (cnt_cw_s) begin
                pos_nxt_s = pos_inc(bus.o_pos);
            end else begin
                pos_nxt_s = pos_dec(bus.o_pos);
            end
        end else begin
            pos_nxt_s = bus.o_pos;
        end
    end

    // Decoder FSM: FILL lets the synchroniser flush stale reset zeros, then
    // the first real sample only seeds prev so it can never count or error.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_FILL;
            fill_r  <= 3'd0;
            prev_r  <= 2'b00;
            q_r     <= 4'sd0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (fill_r == FILL_LAST) begin
                        prev_r  <= phase_s;
                        q_r     <= 4'sd0;
                        state_r <= ST_RUN;
                    end else begin
                        fill_r <= fill_r + 3'd1;
                    end
                end
                ST_RUN: begin
                    prev_r <= phase_s;
                    q_r    <= q_nxt_s;
                end
                default: begin
                    state_r <= ST_FILL;
                    fill_r  <= 3'd0;
                    q_r     <= 4'sd0;
                end
            endcase
        end
    end

    // Registered outputs; the position and its step pulse appear together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_cnt      <= 1'b0;
            bus.o_cnt_cw   <= 1'b0;
            bus.o_err      <= 1'b0;
            bus.o_err_flag <= 1'b0;
            bus.o_pos      <= POS_ZERO;
        end else begin
            bus.o_cnt    <= cnt_s;
            bus.o_cnt_cw <= cnt_cw_s;
            bus.o_err    <= err_s;
            bus.o_pos    <= pos_nxt_s;
            // A new error wins over a simultaneous clear.
            if (err_s) begin
                bus.o_err_flag <= 1'b1;
            end else if (bus.i_clear) begin
                bus.o_err_flag <= 1'b0;
            end else begin
                bus.o_err_flag <= bus.o_err_flag;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder_counter
// Three counter instances with different resolutions/widths/overflow modes.
// Stimulus pushes expected pulses (kind, direction, position, cycle) and
// position/flag probes into queues; one monitor process pops and compares.
//   u0: MODE=0 (x1), CNT_WIDTH=8, WRAP=1
//   u1: MODE=1 (x2), CNT_WIDTH=4, WRAP=1
//   u2: MODE=2 (x4), CNT_WIDTH=4, WRAP=0
// -----------------------------------------------------------------------------
module tb_quad_encoder_counter;

    typedef struct {
        int err;
        int cw;
        int pos;
        int cyc;
    } ev_t;

    typedef struct {
        int k;
        int pos;
        int flag;
    } pr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic done = 1'b0;

    ev_t evq0[$];
    ev_t evq1[$];
    ev_t evq2[$];
    pr_t prq[$];

    quad_encoder_counter_if #(.CNT_WIDTH(8)) bus0 ();
    quad_encoder_counter_if #(.CNT_WIDTH(4)) bus1 ();
    quad_encoder_counter_if #(.CNT_WIDTH(4)) bus2 ();

    quad_encoder_counter #(.CNT_WIDTH(8), .SYNC_STAGES(2), .MODE(0), .WRAP(1)) u0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0.slave));
    quad_encoder_counter #(.CNT_WIDTH(4), .SYNC_STAGES(2), .MODE(1), .WRAP(1)) u1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1.slave));
    quad_encoder_counter #(.CNT_WIDTH(4), .SYNC_STAGES(2), .MODE(2), .WRAP(0)) u2 (
        .i_clk(clk), .i_rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- comparison helpers (monitor process only) ----------
    task automatic chk(input string name, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s u%0d actual=%0d expected=%0d (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input logic cnt, input logic cw, input logic err,
                       input int pos);
        ev_t e;
        int  has;
        has = 0;
        if (!cnt) chk("cw_without_cnt", k, int'(cw), 0);
        chk("cnt_err_exclusive", k, int'(cnt && err), 0);
        if (cnt || err) begin
            case (k)
                0: if (evq0.size() > 0) begin e = evq0.pop_front(); has = 1; end
                1: if (evq1.size() > 0) begin e = evq1.pop_front(); has = 1; end
                default: if (evq2.size() > 0) begin e = evq2.pop_front(); has = 1; end
            endcase
            if (has == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse u%0d cnt=%0d err=%0d pos=%0d (cycle %0d)",
                         k, cnt, err, pos, cyc);
            end else begin
                chk("pulse_kind_err", k, int'(err), e.err);
                chk("pulse_cycle", k, cyc, e.cyc);
                if (e.err == 0) begin
                    chk("cnt_dir", k, int'(cw), e.cw);
                    chk("cnt_pos", k, pos, e.pos);
                end
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        int   pos_a[3];
        logic flag_a[3];
        pr_t  p;
        pos_a[0]  = int'($signed(bus0.o_pos));
        pos_a[1]  = int'($signed(bus1.o_pos));
        pos_a[2]  = int'($signed(bus2.o_pos));
        flag_a[0] = bus0.o_err_flag;
        flag_a[1] = bus1.o_err_flag;
        flag_a[2] = bus2.o_err_flag;
        mon(0, bus0.o_cnt, bus0.o_cnt_cw, bus0.o_err, pos_a[0]);
        mon(1, bus1.o_cnt, bus1.o_cnt_cw, bus1.o_err, pos_a[1]);
        mon(2, bus2.o_cnt, bus2.o_cnt_cw, bus2.o_err, pos_a[2]);
        while (prq.size() > 0) begin
            p = prq.pop_front();
            chk("probe_pos", p.k, pos_a[p.k], p.pos);
            chk("probe_err_flag", p.k, int'(flag_a[p.k]), p.flag);
        end
        if (done) begin
            chk("missing_pulses", 0, evq0.size(), 0);
            chk("missing_pulses", 1, evq1.size(), 0);
            chk("missing_pulses", 2, evq2.size(), 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_ev(input int k, input int ev, input int pos);
        ev_t e;
        e.err = (ev == 3) ? 1 : 0;
        e.cw  = (ev == 1) ? 1 : 0;
        e.pos = pos;
        e.cyc = cyc + 3;   // capture edge + 2 synchroniser/decode edges
        case (k)
            0:       evq0.push_back(e);
            1:       evq1.push_back(e);
            default: evq2.push_back(e);
        endcase
    endtask

    // Drive a phase word on instance k and hold it 5 clocks.
    // ev: 0 = no pulse, 1 = CW count, 2 = CCW count, 3 = error.
    task automatic ph(input int k, input logic [1:0] ab, input int ev, input int pos);
        if (ev != 0) push_ev(k, ev, pos);
        case (k)
            0:       begin bus0.i_phase_a = ab[1]; bus0.i_phase_b = ab[0]; end
            1:       begin bus1.i_phase_a = ab[1]; bus1.i_phase_b = ab[0]; end
            default: begin bus2.i_phase_a = ab[1]; bus2.i_phase_b = ab[0]; end
        endcase
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic probe(input int k, input int pos, input int flag);
        pr_t p;
        p.k = k;
        p.pos = pos;
        p.flag = flag;
        prq.push_back(p);
    endtask

    task automatic clr(input int k);
        case (k)
            0:       bus0.i_clear = 1'b1;
            1:       bus1.i_clear = 1'b1;
            default: bus2.i_clear = 1'b1;
        endcase
        @(posedge clk);
        #1;
        bus0.i_clear = 1'b0;
        bus1.i_clear = 1'b0;
        bus2.i_clear = 1'b0;
    endtask

    task automatic ld(input int k, input int val);
        case (k)
            1:       begin bus1.i_load_val = 4'(val); bus1.i_load = 1'b1; end
            default: begin bus2.i_load_val = 4'(val); bus2.i_load = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        bus1.i_load = 1'b0;
        bus2.i_load = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [1:0] cw_seq[4];
        logic [1:0] ccw_seq[4];
        int         exp_pos;
        cw_seq  = '{2'b10, 2'b11, 2'b01, 2'b00};
        ccw_seq = '{2'b01, 2'b11, 2'b10, 2'b00};

        bus0.i_phase_a = 1'b0; bus0.i_phase_b = 1'b0; bus0.i_clear = 1'b0;
        bus0.i_load = 1'b0; bus0.i_load_val = 8'h00;
        bus1.i_phase_a = 1'b0; bus1.i_phase_b = 1'b0; bus1.i_clear = 1'b0;
        bus1.i_load = 1'b0; bus1.i_load_val = 4'h0;
        bus2.i_phase_a = 1'b0; bus2.i_phase_b = 1'b0; bus2.i_clear = 1'b0;
        bus2.i_load = 1'b0; bus2.i_load_val = 4'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        probe(0, 0, 0);
        probe(1, 0, 0);
        probe(2, 0, 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // u0 x1: three full CW cycles -> +1 per cycle, latency checked.
        for (int c = 0; c < 3; c++)
            for (int j = 0; j < 4; j++)
                ph(0, cw_seq[j], (j == 3) ? 1 : 0, c + 1);
        probe(0, 3, 0);

        // u0 x1: reversal mid-cycle never counts, then one CCW cycle -> -1.
        clr(0);
        probe(0, 0, 0);
        ph(0, 2'b10, 0, 0);
        ph(0, 2'b11, 0, 0);
        ph(0, 2'b10, 0, 0);
        ph(0, 2'b00, 0, 0);
        for (int j = 0; j < 4; j++)
            ph(0, ccw_seq[j], (j == 3) ? 2 : 0, -1);
        probe(0, -1, 0);

        // u2 x4 saturating: load 7, CW holds at 7, CCW saturates at -8.
        ld(2, 7);
        probe(2, 7, 0);
        for (int j = 0; j < 4; j++)
            ph(2, cw_seq[j], 1, 7);
        for (int i = 1; i <= 20; i++) begin
            exp_pos = (7 - i < -8) ? -8 : 7 - i;
            ph(2, ccw_seq[(i - 1) % 4], 2, exp_pos);
        end
        probe(2, -8, 0);

        // u1 x2 wrapping: load -8, CCW half-cycles wrap to 7 then 6.
        ld(1, -8);
        probe(1, -8, 0);
        for (int j = 0; j < 4; j++)
            ph(1, ccw_seq[j], (j == 1 || j == 3) ? 2 : 0, (j == 1) ? 7 : 6);
        probe(1, 6, 0);

        // u0: q built up, then a double-phase jump errors and clears q.
        ph(0, 2'b10, 0, 0);
        ph(0, 2'b11, 0, 0);
        ph(0, 2'b00, 3, 0);
        probe(0, -1, 1);
        for (int c = 0; c < 2; c++)
            for (int j = 0; j < 4; j++)
                ph(0, cw_seq[j], (j == 3) ? 1 : 0, c);
        probe(0, 1, 1);
        clr(0);
        probe(0, 0, 0);

        // Reset while resting at 11 (q=2), then finish the cycle: no count.
        ph(0, 2'b10, 0, 0);
        ph(0, 2'b11, 0, 0);
        rst = 1'b1;
        #1;
        probe(1, 0, 0);
        probe(2, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        ph(0, 2'b01, 0, 0);
        ph(0, 2'b00, 0, 0);
        for (int j = 0; j < 4; j++)
            ph(0, cw_seq[j], (j == 3) ? 1 : 0, 1);
        probe(0, 1, 0);

        repeat (8) @(posedge clk);
        #1;
        done = 1'b1;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/quad_encoder_counter.md
Name: quad_encoder_counter

Overview:
- Parametrised next-generation incremental quadrature encoder driver.
- Synchronises raw A/B phases and decodes them at a selectable resolution (x1 full-cycle, x2, x4).
- Maintains a signed position register with wrap or saturate, load and clear.
- Detects illegal double-phase transitions and sits directly between encoder pins and user logic. No external debouncer is required.

Parameters:
- CNT_WIDTH, 16: width of the signed two's-complement position register (legal range 4..32).
- SYNC_STAGES, 2: number of input synchroniser flops per phase (legal range 2..4).
- MODE, 0: decode resolution. 0 = x1 (one count per full Gray cycle), 1 = x2, 2 = x4. The value 3 is illegal.
- WRAP, 1: 1 = position wraps modulo 2^CNT_WIDTH; 0 = position saturates at the signed max/min.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_phase_a  in  1  raw encoder phase A (asynchronous).
- i_phase_b  in  1  raw encoder phase B (asynchronous).
- i_clear  in  1  synchronous: position := 0, sticky error := 0.
- i_load  in  1  synchronous: position := i_load_val.
- i_load_val  in  CNT_WIDTH  load value.
- o_cnt  out  1  one-cycle pulse per counted step.
- o_cnt_cw  out  1  direction of the step; valid only while o_cnt=1 (1 = CW).
- o_pos  out  CNT_WIDTH  signed position.
- o_err  out  1  one-cycle pulse on an illegal transition.
- o_err_flag  out  1  sticky error flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - Synchroniser flops 0, fill counter 0, decoder state FILL, quarter accumulator q = 0.
- Phase word P = {a,b} taken from the last synchroniser stage.
- CW Gray sequence: 00→10→11→01→00 (A leads). CCW is the reverse.
- FILL state: wait SYNC_STAGES cycles after reset release. Then load prev := P with no decode and no error, and go to RUN.
- RUN state, each cycle compare P with prev:
  - Equal: nothing happens.
  - Legal CW step: q := q+1.
  - Legal CCW step: q := q−1.
  - Both bits changed: o_err=1 for one cycle, o_err_flag := 1, q := 0, no count.
  - prev := P in every case.
- Anchor states and period:
  - x1: anchor {00}, period 4.
  - x2: anchors {00, 11}, period 2.
  - x4: every state is an anchor, period 1.
- On a legal step into an anchor:
  - If q_new = +period: o_cnt=1, o_cnt_cw=1, position +1.
  - If q_new = −period: o_cnt=1, o_cnt_cw=0, position −1.
  - In all cases q := 0 on entering an anchor. A partial or reversed cycle therefore never counts, which provides jitter immunity.
- q is a 4-bit signed value and can never exceed ±3 between anchors.
- Latency: a phase edge first captured at clock edge k produces o_cnt and the updated o_pos after edge k+SYNC_STAGES. o_pos and o_cnt update in the same cycle.
- Position arithmetic:
  - WRAP=1: max+1 → min and min−1 → max.
  - WRAP=0: the value holds at max/min, and o_cnt still pulses with the correct direction.
- Priority within a single cycle: i_clear > i_load > step.
  - With i_clear or i_load active, a coincident step still pulses o_cnt/o_cnt_cw, but the position takes the clear/load value.
  - i_clear also drops o_err_flag. An error pulse in the same cycle as i_clear leaves the flag at 1 (set wins).
- Error pulse and count pulse are mutually exclusive.
- Reset asserted mid-operation clears everything immediately and re-enters FILL. The first sample after FILL never produces a count or an error, whatever the phase value.
- o_cnt_cw is 0 whenever o_cnt=0.

Test Plan:
- MODE=0, CNT_WIDTH=8, WRAP=1: three CW cycles from 00, each phase held 5 clocks → exactly 3 o_cnt pulses with o_cnt_cw=1; o_pos=3; each pulse at edge+2.
- MODE=0: 00→10→11→10→00 (reversal mid-cycle), then one full CCW cycle → no pulse for the reversal; one pulse with cw=0; o_pos=−1 (0xFF).
- MODE=2, CNT_WIDTH=4, WRAP=0: i_load with 7, then 4 CW steps → 4 o_cnt pulses, o_pos stays 7; then 20 CCW steps → o_pos saturates at −8 (0x8).
- MODE=1, WRAP=1, CNT_WIDTH=4: load −8, then 2 CCW half-cycles (00→01→11→10→00) → o_pos = 7 then 6; one pulse per anchor.
- Any mode: 00→11 in one cycle → o_err=1 for one cycle, o_err_flag=1, no o_cnt, q cleared; later i_clear → o_pos=0, o_err_flag=0.
- Reset while encoder rests at 11, release, then CW to 01→00 in MODE=0 → no error after FILL, no count (q=2 at anchor); the next full CW cycle counts once.
